// File: rtl/fpdecode.sv
// ----------------------------------------------------------------------------
// fpdecode
//
// Purpose:
//   Iterative decoder from an 8-bit floating-point code (sign, 3-bit exponent
//   E, 4-bit significand F) to a 12-bit two's-complement linear sample.
//   The magnitude F << E is rebuilt one bit per cycle by a small left
//   shifter under an FSM. The signed result is registered and held until
//   the consumer takes it.
//
// Handshake (both ports):
//   A transfer happens on a rising edge where valid and ready are both
//   high. The producer keeps in_code stable while in_valid is high and
//   in_ready is low. out/out_valid stay stable until out_ready is seen.
//   in_ready depends only on the FSM state, never on in_valid or out_ready.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous, active-high reset
//   in_code    in   8   [7] sign, [6:4] exponent E, [3:0] significand F
//   in_valid   in   1   in_code is valid this cycle
//   in_ready   out  1   block can accept a code (IDLE only)
//   out        out  12  registered two's-complement result
//   out_valid  out  1   out holds a completed result
//   out_ready  in   1   consumer accepts out this cycle
//   busy       out  1   FSM is in any state other than IDLE
// ----------------------------------------------------------------------------
module fpdecode (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_code,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q;
    logic        sign_q;
    logic [2:0]  cnt_q;
    logic [10:0] acc_q;
    logic [11:0] out_q;
    logic        out_valid_q;

    logic [10:0] acc_d;
    logic [11:0] result_d;

    // Shifted accumulator and signed result. The largest magnitude is
    // 15 << 7 = 1920, so the 11-bit accumulator never overflows and the
    // negated value always fits in 12 bits.
    always_comb begin
        acc_d    = acc_q << 1;
        result_d = {1'b0, acc_q};
        if (sign_q) begin
            result_d = 12'd0 - {1'b0, acc_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            cnt_q       <= 3'd0;
            acc_q       <= 11'd0;
            out_q       <= 12'h000;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_code[7];
                        cnt_q  <= in_code[6:4];
                        acc_q  <= {7'b0, in_code[3:0]};
                        // E = 0 needs no shifting at all.
                        if (in_code[6:4] != 3'd0) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 3'd1;
                    // cnt_q == 1 means this edge performs the final shift.
                    if (cnt_q == 3'd1) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    out_q       <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    // out_q keeps its last value after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fpdecode.sv
// ----------------------------------------------------------------------------
// tb_fpdecode
//
// Self-checking bench for fpdecode. Inputs change on the falling edge and
// outputs are sampled on the falling edge, so every observation sits half a
// cycle away from the active rising edge. Expected values come from an
// arithmetic model of the code format (F * 2^E with the sign applied,
// reduced mod 4096).
// ----------------------------------------------------------------------------
module tb_fpdecode;

    logic        clk;
    logic        rst;
    logic [7:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int vectors;
    int miscompares;

    fpdecode dut (
        .clk       (clk),
        .rst       (rst),
        .in_code   (in_code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: value = (+/-) F * 2^E, wrapped to 12 bits.
    // ------------------------------------------------------------------
    function automatic logic [11:0] model(input logic [7:0] c);
        int m;
        m = int'(c[3:0]) * (1 << int'(c[6:4]));
        if (c[7]) m = 0 - m;
        return m[11:0];
    endfunction

    function automatic int exp_of(input logic [7:0] c);
        return int'(c[6:4]);
    endfunction

    // ------------------------------------------------------------------
    // Driver: present one code, wait for the result, complete the output
    // handshake. Returns the result and the number of cycles from the
    // accepting edge until out_valid was seen.
    // ------------------------------------------------------------------
    task automatic run_one(input logic [7:0] code, output logic [11:0] res,
                           output int lat);
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_code  = code;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_code   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (out !== 12'h000 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: out=%h out_valid=%b in_ready=%b busy=%b, want 000/0/1/0",
                     out, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [11:0] res;
        // Directed code with per-cycle status checks.
        @(negedge clk);
        in_code  = 8'b0_011_1010;
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: in_ready=%b busy=%b, want 1/0", in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_busy: cycle %0d in_ready=%b busy=%b, want 0/1", lat, in_ready, busy);
            end
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL basic_latency_3A: got %0d cycles, want 4", lat);
        end
        vectors++;
        if (out !== 12'h050) begin
            miscompares++;
            $display("FAIL basic_out_3A: got %h, want 050", out);
        end
        vectors++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_hold: in_ready=%b busy=%b, want 0/1", in_ready, busy);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release: in_ready=%b busy=%b out_valid=%b, want 1/0/0",
                     in_ready, busy, out_valid);
        end

        run_one(8'b0_000_0101, res, lat);
        vectors++;
        if (res !== 12'h005 || lat !== 1) begin
            miscompares++;
            $display("FAIL basic_05: out=%h lat=%0d, want 005 lat 1", res, lat);
        end
        run_one(8'b1_111_1111, res, lat);
        vectors++;
        if (res !== 12'h880 || lat !== 8) begin
            miscompares++;
            $display("FAIL basic_FF: out=%h lat=%0d, want 880 lat 8", res, lat);
        end
    endtask

    task automatic test_edge_codes();
        int lat;
        logic [11:0] res;
        // Prime out with a nonzero value so a zero result is a real change.
        run_one(8'b0_010_0011, res, lat);
        run_one(8'b1_000_0000, res, lat);
        vectors++;
        if (res !== 12'h000 || lat !== 1) begin
            miscompares++;
            $display("FAIL edge_neg_zero: out=%h lat=%0d, want 000 lat 1", res, lat);
        end
        run_one(8'b0_010_0011, res, lat);
        run_one(8'b1_101_0000, res, lat);
        vectors++;
        if (res !== 12'h000 || lat !== 6) begin
            miscompares++;
            $display("FAIL edge_zero_E5: out=%h lat=%0d, want 000 lat 6", res, lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  order[256];
        logic [7:0]  tmp;
        logic [11:0] res;
        int lat;
        int j;
        for (int i = 0; i < 256; i++) order[i] = 8'(i);
        // Random visiting order so consecutive codes vary.
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_one(order[i], res, lat);
            vectors++;
            if (res !== model(order[i]) || lat !== exp_of(order[i]) + 1) begin
                miscompares++;
                $display("FAIL sweep code=%h: out=%h lat=%0d, want %h lat %0d",
                         order[i], res, lat, model(order[i]), exp_of(order[i]) + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  code;
        logic [11:0] want;
        int lat;
        code = 8'($urandom_range(0, 255));
        code[3:0] = 4'($urandom_range(1, 15));
        want = model(code);
        @(negedge clk);
        in_code  = code;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
        end
        // Stall the consumer while offering a different code.
        in_code  = ~code;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (out !== want || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_stall cycle %0d: out=%h ov=%b in_ready=%b, want %h/1/0",
                         k, out, out_valid, in_ready, want);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== want) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b ov=%b out=%h, want 1/0/%h",
                     in_ready, out_valid, out, want);
        end
        // The code offered during the stall must not have been captured.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ignored cycle %0d: ov=%b busy=%b, want 0/0", k, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] code;
        code = {1'($urandom_range(0, 1)), 3'd6, 4'($urandom_range(1, 15))};
        @(negedge clk);
        in_code  = code;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy: busy=%b, want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out !== 12'h000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_after: ov=%b out=%h in_ready=%b busy=%b, want 0/000/1/0",
                     out_valid, out, in_ready, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || out !== 12'h000 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rstmid_stale cycle %0d: ov=%b out=%h in_ready=%b, want 0/000/1",
                         k, out_valid, out, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  codes[20];
        logic [11:0] exp_q[$];
        logic [7:0]  prev_code;
        int n_acc;
        int n_out;
        int cyc;
        int last_acc;
        bit after_accept;
        for (int i = 0; i < 20; i++) codes[i] = 8'($urandom_range(0, 255));
        @(negedge clk);
        in_code      = codes[0];
        in_valid     = 1'b1;
        out_ready    = 1'b1;
        n_acc        = 0;
        n_out        = 0;
        cyc          = 0;
        last_acc     = 0;
        prev_code    = 8'h00;
        after_accept = 1'b0;
        while (n_out < 20 && cyc < 2000) begin
            if (after_accept) begin
                after_accept = 1'b0;
                if (n_acc < 20) in_code = codes[n_acc];
                else            in_valid = 1'b0;
            end
            vectors++;
            if (out_valid === 1'b1 && in_ready === 1'b1) begin
                miscompares++;
                $display("FAIL b2b_overlap cycle %0d: out_valid and in_ready both high", cyc);
            end
            if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra: out=%h with no expected result", out);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        miscompares++;
                        $display("FAIL b2b_out #%0d: got %h, want %h", n_out, out, e);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(model(in_code));
                if (n_acc > 0) begin
                    vectors++;
                    if (cyc - last_acc !== exp_of(prev_code) + 3) begin
                        miscompares++;
                        $display("FAIL b2b_gap #%0d: got %0d cycles, want %0d",
                                 n_acc, cyc - last_acc, exp_of(prev_code) + 3);
                    end
                end
                prev_code    = in_code;
                last_acc     = cyc;
                n_acc++;
                after_accept = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (n_out !== 20 || n_acc !== 20) begin
            miscompares++;
            $display("FAIL b2b_count: accepted %0d produced %0d, want 20/20", n_acc, n_out);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_edge_codes();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
